// File: rtl/mem_stage_sb_pkg.sv
// Shared definitions for the MEM stage: instruction short codes, access lengths,
// memctrl-port FSM states and small decode helpers.
package mem_stage_sb_pkg;

  localparam int INST_W = 4;
  localparam int REG_W  = 5;

  localparam logic [INST_W-1:0] INST_NOP = 4'd0;
  localparam logic [INST_W-1:0] INST_LB  = 4'd1;
  localparam logic [INST_W-1:0] INST_LH  = 4'd2;
  localparam logic [INST_W-1:0] INST_LW  = 4'd3;
  localparam logic [INST_W-1:0] INST_LBU = 4'd4;
  localparam logic [INST_W-1:0] INST_LHU = 4'd5;
  localparam logic [INST_W-1:0] INST_SB  = 4'd6;
  localparam logic [INST_W-1:0] INST_SH  = 4'd7;
  localparam logic [INST_W-1:0] INST_SW  = 4'd8;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ST_BUSY = 2'd1,
    S_LD_BUSY = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [INST_W-1:0] inst);
    return inst inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU};
  endfunction

  function automatic logic is_store(input logic [INST_W-1:0] inst);
    return inst inside {INST_SB, INST_SH, INST_SW};
  endfunction

  function automatic logic [2:0] len_of(input logic [INST_W-1:0] inst);
    case (inst)
      INST_LB, INST_LBU, INST_SB: return LEN_B;
      INST_LH, INST_LHU, INST_SH: return LEN_H;
      default:                    return LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_store_buffer.sv
// Circular store FIFO with a combinational CAM that finds the youngest entry
// overlapping a load's byte range and classifies it as a full hit or a partial overlap.
module mem_store_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          enq_i,
  input  logic [ADDR_W-1:0]             enq_addr_i,
  input  logic [DATA_W-1:0]             enq_data_i,
  input  logic [2:0]                    enq_len_i,
  input  logic                          pop_i,
  input  logic [ADDR_W-1:0]             lk_addr_i,
  input  logic [2:0]                    lk_len_i,
  output logic                          hit_o,
  output logic                          partial_o,
  output logic [DATA_W-1:0]             fwd_data_o,
  output logic [ADDR_W-1:0]             head_addr_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [2:0]                    head_len_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          empty_o,
  output logic                          full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AW1   = ADDR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [2:0]        len_q  [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic [DEPTH-1:0]  ovl;
  logic [PTR_W-1:0]  sel, idx;
  logic              any_ovl;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // Clear before set so a full-buffer pop+enqueue on the same slot stays valid.
      if (pop_i) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (enq_i) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      case ({enq_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (enq_i) begin
      addr_q[tail_q] <= enq_addr_i;
      data_q[tail_q] <= enq_data_i;
      len_q[tail_q]  <= enq_len_i;
    end
  end

  // Byte ranges are compared one bit wider than the address so a+len cannot wrap.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ovl
    logic [ADDR_W:0] e_lo, e_hi, l_lo, l_hi;
    assign e_lo    = {1'b0, addr_q[gi]};
    assign e_hi    = e_lo + AW1'(len_q[gi]);
    assign l_lo    = {1'b0, lk_addr_i};
    assign l_hi    = l_lo + AW1'(lk_len_i);
    assign ovl[gi] = valid_q[gi] && (l_lo < e_hi) && (e_lo < l_hi);
  end

  always_comb begin
    any_ovl = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (ovl[idx]) begin
        any_ovl = 1'b1;
        sel     = idx;
      end
    end
  end

  assign hit_o       = any_ovl && (addr_q[sel] == lk_addr_i) && (len_q[sel] >= lk_len_i);
  assign partial_o   = any_ovl && !hit_o;
  assign fwd_data_o  = data_q[sel];
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];
  assign head_len_o  = len_q[head_q];
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/mem_stage_sb.sv
// MEM pipeline stage: stores retire into a store buffer, loads forward from it or
// go to memctrl; a three-process FSM owns the single memctrl port.
module mem_stage_sb
  import mem_stage_sb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SB_DEPTH = 4,
  parameter int IO_LSB   = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              valid_in,
  input  logic [INST_W-1:0] inst_in,
  input  logic [REG_W-1:0]  rd_address_in,
  input  logic [DATA_W-1:0] rd_data_in,
  input  logic [ADDR_W-1:0] mem_address_in,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_out,
  output logic              mem_get,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic [2:0]        mem_len,
  output logic [REG_W-1:0]  rd_address,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_rd_done,
  output logic              stall_out,
  output logic              sb_empty
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  mem_state_e        state_q, state_d;
  logic              is_ld, is_st, is_io, ld_issue, pop, enq;
  logic              lk_hit, lk_partial, sb_full;
  logic [2:0]        acc_len, head_len;
  logic [DATA_W-1:0] st_mask, fwd_data, head_data;
  logic [ADDR_W-1:0] head_addr;
  logic [CNT_W-1:0]  sb_count;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [INST_W-1:0] inst);
    case (inst)
      INST_LB:  return {{(DATA_W-8){d[7]}}, d[7:0]};
      INST_LH:  return {{(DATA_W-16){d[15]}}, d[15:0]};
      INST_LBU: return {{(DATA_W-8){1'b0}}, d[7:0]};
      INST_LHU: return {{(DATA_W-16){1'b0}}, d[15:0]};
      default:  return d;
    endcase
  endfunction

  assign is_ld   = valid_in && is_load(inst_in);
  assign is_st   = valid_in && is_store(inst_in);
  assign is_io   = (mem_address_in[IO_LSB+1:IO_LSB] == 2'b11);
  assign acc_len = len_of(inst_in);
  assign st_mask = (acc_len == LEN_B) ? {{(DATA_W-8){1'b0}}, 8'hFF} :
                   (acc_len == LEN_H) ? {{(DATA_W-16){1'b0}}, 16'hFFFF} : '1;

  // IO loads only go once the buffer is fully drained; normal loads need no overlap.
  assign ld_issue = is_ld && (is_io ? (sb_count == '0) : !(lk_hit || lk_partial));
  assign pop      = rdy_in && (state_q == S_ST_BUSY) && mem_done;
  assign enq      = rdy_in && is_st && (!sb_full || pop);

  mem_store_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (SB_DEPTH)
  ) u_sb (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .enq_i       (enq),
    .enq_addr_i  (mem_address_in),
    .enq_data_i  (rd_data_in & st_mask),
    .enq_len_i   (acc_len),
    .pop_i       (pop),
    .lk_addr_i   (mem_address_in),
    .lk_len_i    (acc_len),
    .hit_o       (lk_hit),
    .partial_o   (lk_partial),
    .fwd_data_o  (fwd_data),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .head_len_o  (head_len),
    .count_o     (sb_count),
    .empty_o     (sb_empty),
    .full_o      (sb_full)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   state_q <= S_IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ld_issue)             state_d = S_LD_BUSY;
        else if (sb_count != '0)  state_d = S_ST_BUSY;
      end
      S_ST_BUSY: if (mem_done) state_d = S_IDLE;
      S_LD_BUSY: if (mem_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The load address is taken live from ex_mem, which is held by stall_out until mem_done.
  always_comb begin
    mem_get     = 1'b0;
    mem_wr      = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    mem_len     = 3'd0;
    case (state_q)
      S_ST_BUSY: begin
        mem_get     = 1'b1;
        mem_wr      = 1'b1;
        mem_address = head_addr;
        mem_data    = head_data;
        mem_len     = head_len;
      end
      S_LD_BUSY: begin
        mem_get     = 1'b1;
        mem_address = mem_address_in;
        mem_len     = acc_len;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_address  = rd_address_in;
    rd_data     = rd_data_in;
    mem_rd_done = valid_in && (inst_in != INST_NOP);
    stall_out   = 1'b0;
    if (is_st) begin
      rd_address  = '0;
      rd_data     = '0;
      mem_rd_done = 1'b0;
      stall_out   = sb_full && !pop;
    end else if (is_ld) begin
      rd_data     = '0;
      mem_rd_done = 1'b0;
      stall_out   = 1'b1;
      if (!is_io && lk_hit) begin
        rd_data     = extend(fwd_data, inst_in);
        mem_rd_done = 1'b1;
        stall_out   = 1'b0;
      end else if ((state_q == S_LD_BUSY) && mem_done) begin
        rd_data     = extend(mem_out, inst_in);
        mem_rd_done = 1'b1;
        stall_out   = 1'b0;
      end
    end
    if (!rdy_in) stall_out = 1'b1;
  end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: stimulus pushes expected register results and
// memctrl transactions into queues; two monitors pop and compare as the DUT produces them.
module tb_mem_stage_sb;
  import mem_stage_sb_pkg::*;

  localparam logic [3:0] INST_ALU = 4'd9;
  localparam int         MC_DLY   = 3;

  logic        clk = 1'b0;
  logic        rst_n, rdy_in, valid_in;
  logic [3:0]  inst_in;
  logic [4:0]  rd_address_in;
  logic [31:0] rd_data_in, mem_address_in;
  logic        mem_done;
  logic [31:0] mem_out;
  logic        mem_get, mem_wr;
  logic [31:0] mem_address, mem_data;
  logic [2:0]  mem_len;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;
  logic        mem_rd_done, stall_out, sb_empty;

  always #5 clk = ~clk;

  mem_stage_sb #(.ADDR_W(32), .DATA_W(32), .SB_DEPTH(4), .IO_LSB(16)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy_in),
    .valid_in       (valid_in),
    .inst_in        (inst_in),
    .rd_address_in  (rd_address_in),
    .rd_data_in     (rd_data_in),
    .mem_address_in (mem_address_in),
    .mem_done       (mem_done),
    .mem_out        (mem_out),
    .mem_get        (mem_get),
    .mem_wr         (mem_wr),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .mem_len        (mem_len),
    .rd_address     (rd_address),
    .rd_data        (rd_data),
    .mem_rd_done    (mem_rd_done),
    .stall_out      (stall_out),
    .sb_empty       (sb_empty)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  len;
    logic        chk_empty;
  } mop_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } rdr_t;

  mop_t exp_mem[$];
  rdr_t exp_rd[$];
  mop_t mop;
  rdr_t rdr;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Memctrl model: byte memory preloaded with addr[7:0]^A5, fixed latency.
  logic [7:0] mem_b [4096];
  int         mc_cnt;

  function automatic logic [31:0] rdm(input logic [31:0] a, input logic [2:0] l);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(l)) r[8*i +: 8] = mem_b[a[11:0] + 12'(i)];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_done <= 1'b0;
      mem_out  <= '0;
      mc_cnt   <= 0;
      for (int i = 0; i < 4096; i++) mem_b[i] <= 8'(i) ^ 8'hA5;
    end else begin
      mem_done <= 1'b0;
      if (mem_get && !mem_done) begin
        if (mc_cnt == MC_DLY - 1) begin
          mc_cnt   <= 0;
          mem_done <= 1'b1;
          if (mem_wr) begin
            for (int i = 0; i < 4; i++)
              if (i < int'(mem_len)) mem_b[mem_address[11:0] + 12'(i)] <= mem_data[8*i +: 8];
          end else begin
            mem_out <= rdm(mem_address, mem_len);
          end
        end else begin
          mc_cnt <= mc_cnt + 1;
        end
      end
    end
  end

  // Register-result monitor
  always @(negedge clk) begin
    if (rst_n && rdy_in && mem_rd_done) begin
      if (exp_rd.size() == 0) begin
        timeout_fail("rd_unexpected");
      end else begin
        rdr = exp_rd.pop_front();
        $display("rd  x%0d = %h (expect x%0d = %h)", rd_address, rd_data, rdr.rd, rdr.data);
        chk("rd_address", 32'(rd_address), 32'(rdr.rd));
        chk("rd_data", rd_data, rdr.data);
      end
    end
  end

  // Memctrl transaction monitor
  always @(negedge clk) begin
    if (rst_n && mem_get && mem_done) begin
      $display("mem wr=%0d addr=%h data=%h len=%0d", mem_wr, mem_address, mem_data, mem_len);
      if (exp_mem.size() == 0) begin
        timeout_fail("mem_unexpected");
      end else begin
        mop = exp_mem.pop_front();
        chk("mem_wr", 32'(mem_wr), 32'(mop.wr));
        chk("mem_address", mem_address, mop.addr);
        chk("mem_len", 32'(mem_len), 32'(mop.len));
        if (mop.wr) chk("mem_data", mem_data, mop.data);
        if (mop.chk_empty) chk("io_after_empty", 32'(sb_empty), 32'd1);
      end
    end
  end

  task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
    exp_mem.push_back('{wr: 1'b1, addr: a, data: d, len: l, chk_empty: 1'b0});
  endtask

  task automatic push_r(input logic [31:0] a, input logic [2:0] l, input logic ce);
    exp_mem.push_back('{wr: 1'b0, addr: a, data: 32'h0, len: l, chk_empty: ce});
  endtask

  task automatic push_rd(input logic [4:0] r, input logic [31:0] d);
    exp_rd.push_back('{rd: r, data: d});
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction leaves ex_mem.
  task automatic issue(input logic [3:0] inst, input logic [4:0] rd, input logic [31:0] d,
                       input logic [31:0] a, output int stalls, output logic done_at_acc);
    valid_in       = 1'b1;
    inst_in        = inst;
    rd_address_in  = rd;
    rd_data_in     = d;
    mem_address_in = a;
    stalls         = 0;
    done_at_acc    = 1'b0;
    forever begin
      @(negedge clk);
      if (!stall_out) begin
        done_at_acc = mem_done;
        break;
      end
      stalls++;
      if (stalls > 300) begin
        timeout_fail("issue_stall");
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_in       = 1'b0;
    inst_in        = INST_NOP;
    rd_address_in  = '0;
    rd_data_in     = '0;
    mem_address_in = '0;
  endtask

  task automatic wait_empty();
    int n = 0;
    forever begin
      @(negedge clk);
      if (sb_empty && !mem_get) break;
      n++;
      if (n > 400) begin
        timeout_fail("drain");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_get"}, 32'(mem_get), 32'd0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    chk({tag, "_mem_address"}, mem_address, 32'd0);
    chk({tag, "_mem_data"}, mem_data, 32'd0);
    chk({tag, "_mem_len"}, 32'(mem_len), 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_mem_rd_done"}, 32'(mem_rd_done), 32'd0);
    chk({tag, "_stall_out"}, 32'(stall_out), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb_empty), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   st;
    logic ad;
    rst_n          = 1'b0;
    rdy_in         = 1'b1;
    valid_in       = 1'b0;
    inst_in        = INST_NOP;
    rd_address_in  = '0;
    rd_data_in     = '0;
    mem_address_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store then load of the same word forwards with no memctrl read
    push_w(32'h100, 32'h12345678, 3'd4);
    issue(INST_SW, 5'd0, 32'h12345678, 32'h100, st, ad);
    push_rd(5'd5, 32'h12345678);
    issue(INST_LW, 5'd5, 32'h0, 32'h100, st, ad);
    chk("t1_hit_no_stall", 32'(st), 32'd0);
    wait_empty();

    // Byte store: LB forwards sign-extended, LW overlaps partially and waits for drain
    push_w(32'h200, 32'h80, 3'd1);
    issue(INST_SB, 5'd0, 32'h12345680, 32'h200, st, ad);
    push_rd(5'd6, 32'hFFFFFF80);
    issue(INST_LB, 5'd6, 32'h0, 32'h200, st, ad);
    chk("t2_lb_no_stall", 32'(st), 32'd0);
    push_r(32'h200, 3'd4, 1'b0);
    push_rd(5'd7, 32'hA6A7A480);
    issue(INST_LW, 5'd7, 32'h0, 32'h200, st, ad);
    chk("t2_partial_stalled", 32'(st > 0), 32'd1);
    wait_empty();

    // Five back-to-back stores into a 4-deep buffer
    for (int k = 0; k < 5; k++) push_w(32'h500 + 32'(4*k), 32'(k + 1), 3'd4);
    for (int k = 0; k < 5; k++) begin
      issue(INST_SW, 5'd0, 32'(k + 1), 32'h500 + 32'(4*k), st, ad);
      if (k < 4) begin
        chk("t3_no_stall", 32'(st), 32'd0);
      end else begin
        chk("t3_full_stall", 32'(st > 0), 32'd1);
        chk("t3_accept_on_pop", 32'(ad), 32'd1);
      end
    end
    wait_empty();

    // IO load waits for an empty buffer
    push_w(32'h300, 32'h0BADC0DE, 3'd4);
    push_r(32'h30004, 3'd4, 1'b1);
    issue(INST_SW, 5'd0, 32'h0BADC0DE, 32'h300, st, ad);
    push_rd(5'd9, 32'hA2A3A0A1);
    issue(INST_LW, 5'd9, 32'h0, 32'h30004, st, ad);
    wait_empty();

    // Miss load overtakes queued stores once the in-flight store completes
    push_w(32'h600, 32'h11111111, 3'd4);
    push_r(32'h400, 3'd4, 1'b0);
    push_w(32'h604, 32'h22222222, 3'd4);
    push_w(32'h608, 32'h33333333, 3'd4);
    issue(INST_SW, 5'd0, 32'h11111111, 32'h600, st, ad);
    issue(INST_SW, 5'd0, 32'h22222222, 32'h604, st, ad);
    issue(INST_SW, 5'd0, 32'h33333333, 32'h608, st, ad);
    push_rd(5'd10, 32'hA6A7A4A5);
    issue(INST_LW, 5'd10, 32'h0, 32'h400, st, ad);
    wait_empty();

    // Non-memory op passes through; a live NOP reports nothing
    push_rd(5'd3, 32'hDEAD0001);
    issue(INST_ALU, 5'd3, 32'hDEAD0001, 32'h0, st, ad);
    chk("alu_no_stall", 32'(st), 32'd0);
    issue(INST_NOP, 5'd4, 32'h5, 32'h0, st, ad);

    // Reset in the middle of a store transaction
    issue(INST_SW, 5'd0, 32'h77, 32'h700, st, ad);
    begin
      int n = 0;
      forever begin
        @(negedge clk);
        if (mem_get) break;
        n++;
        if (n > 50) begin
          timeout_fail("t6_wait_get");
          break;
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_w(32'h710, 32'h5A5A5A5A, 3'd4);
    issue(INST_SW, 5'd0, 32'h5A5A5A5A, 32'h710, st, ad);
    chk("t6_store_after_reset", 32'(st), 32'd0);
    push_rd(5'd11, 32'h5A5A5A5A);
    issue(INST_LW, 5'd11, 32'h0, 32'h710, st, ad);
    push_w(32'h720, 32'h0000F234, 3'd2);
    issue(INST_SH, 5'd0, 32'hABCDF234, 32'h720, st, ad);
    push_rd(5'd12, 32'hFFFFF234);
    issue(INST_LH, 5'd12, 32'h0, 32'h720, st, ad);
    push_rd(5'd13, 32'h0000F234);
    issue(INST_LHU, 5'd13, 32'h0, 32'h720, st, ad);
    wait_empty();

    // rdy_in low freezes the stage: stall asserted, store not taken
    rdy_in         = 1'b0;
    valid_in       = 1'b1;
    inst_in        = INST_SW;
    rd_data_in     = 32'h88;
    mem_address_in = 32'h800;
    repeat (3) begin
      @(negedge clk);
      chk("rdy0_stall", 32'(stall_out), 32'd1);
      chk("rdy0_no_enq", 32'(sb_empty), 32'd1);
    end
    @(posedge clk);
    #1;
    valid_in       = 1'b0;
    inst_in        = INST_NOP;
    rd_data_in     = '0;
    mem_address_in = '0;
    rdy_in         = 1'b1;

    repeat (12) @(posedge clk);
    #1;
    chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
